// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with tear-free, frame-aligned value updates.
// Latency: SEG/NA are registered one cycle behind the digit index; staged values appear at the next frame wrap.
// Backpressure: Load is accepted only while Busy=0; requests made while Busy=1 are dropped.
// Optional: define SEG_SCAN_LEADING_ZERO_BLANK_EN to blank digits above the most-significant nonzero nibble.
module seg_scan_ctrl #(
    parameter int ReloadValue = 200000,
    parameter int NrOfBits    = 24
) (
    input  logic        FPGA_GlobalClock,
    input  logic        RST_N,
    input  logic        En,
    input  logic [31:0] Value,
    input  logic [7:0]  DotMask,
    input  logic        Load,
    output logic        Busy,
    output logic        Done,
    output logic [7:0]  SEG,
    output logic [7:0]  NA
);

    localparam logic [NrOfBits-1:0] LastCount = NrOfBits'(ReloadValue - 1);

    logic [NrOfBits-1:0] presc;
    logic [2:0]          digit;
    logic [31:0]         disp;
    logic [31:0]         stage;
    logic                tick;
    logic                frame_end;
    logic [3:0]          nibble;
    logic [6:0]          seg7;
    logic                blank;

    // A tick ends each digit slot; the tick out of digit 7 is the frame boundary.
    assign tick      = En && (presc == LastCount);
    assign frame_end = tick && (digit == 3'd7);

    // Prescaler: counts slot clocks, frozen while the display is disabled.
    always_ff @(posedge FPGA_GlobalClock) begin
        if (!RST_N) begin
            presc <= '0;
        end else if (En) begin
            presc <= tick ? '0 : presc + NrOfBits'(1);
        end
    end

    // Digit index: advances once per slot, wrapping 7 -> 0.
    always_ff @(posedge FPGA_GlobalClock) begin
        if (!RST_N) begin
            digit <= '0;
        end else if (tick) begin
            digit <= digit + 3'd1;
        end
    end

    // Update handshake: stage on an accepted Load, publish only at a frame boundary.
    // A Load accepted on a boundary cycle finds Busy=0, so it waits for the following wrap.
    always_ff @(posedge FPGA_GlobalClock) begin
        if (!RST_N) begin
            stage <= '0;
            disp  <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (!Busy) begin
                if (Load) begin
                    stage <= Value;
                    Busy  <= 1'b1;
                end
            end else if (frame_end) begin
                disp <= stage;
                Busy <= 1'b0;
                Done <= 1'b1;
            end
        end
    end

    // Select the nibble for the digit currently being scanned.
    always_comb begin
        nibble = disp[{digit, 2'b00} +: 4];
    end

    // Active-low hex decode, bit0 = a .. bit6 = g.
    always_comb begin
        seg7 = 7'h7F;
        case (nibble)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            4'hF: seg7 = 7'h0E;
            default: seg7 = 7'h7F;
        endcase
    end

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    logic [2:0] msd;

    // Find the most-significant nonzero nibble; digit 0 is always shown.
    always_comb begin
        msd = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (disp[k*4 +: 4] != 4'h0) begin
                msd = 3'(k);
            end
        end
        blank = (digit > msd);
    end
`else
    // Every digit is decoded.
    always_comb begin
        blank = 1'b0;
    end
`endif

    // Registered drivers: dark while disabled, otherwise one anode low with its decoded pattern.
    always_ff @(posedge FPGA_GlobalClock) begin
        if (!RST_N) begin
            NA  <= 8'hFF;
            SEG <= 8'hFF;
        end else if (!En) begin
            NA  <= 8'hFF;
            SEG <= 8'hFF;
        end else begin
            NA  <= ~(8'h01 << digit);
            SEG <= blank ? 8'hFF : {~DotMask[digit], seg7};
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a short slot (ReloadValue=4, 32 clocks per frame).
// Inputs change on the falling edge; outputs are checked on the following falling edge.
// Table covers reset and the first frame and a quarter; hand sequences cover Load, En freeze, reset and boundary cases.
module tb_seg_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] value;
    logic [7:0]  dot_mask;
    logic        load;
    logic        busy;
    logic        done;
    logic [7:0]  seg;
    logic [7:0]  na;

    int n_chk;
    int n_fail;

    seg_scan_ctrl #(
        .ReloadValue(4),
        .NrOfBits   (24)
    ) dut (
        .FPGA_GlobalClock(clk),
        .RST_N           (rst_n),
        .En              (en),
        .Value           (value),
        .DotMask         (dot_mask),
        .Load            (load),
        .Busy            (busy),
        .Done            (done),
        .SEG             (seg),
        .NA              (na)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [7:0] dm;
        logic [7:0] na;
        logic [7:0] seg;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[42];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    function automatic logic [7:0] anode(input int slot);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << ((slot / 4) % 8));
    endfunction

    initial begin
        logic [7:0] exp_seg;
        int d;
        n_chk  = 0;
        n_fail = 0;

        // Two reset cycles, then 40 scan cycles; DotMask=0x20 during digits 5 and 6.
        for (int i = 0; i < 2; i++) begin
            tbl[i] = '{rst_n: 1'b0, en: 1'b1, dm: 8'h00, na: 8'hFF, seg: 8'hFF, busy: 1'b0, done: 1'b0};
        end
        for (int i = 0; i < 40; i++) begin
            tbl[2+i].rst_n = 1'b1;
            tbl[2+i].en    = 1'b1;
            tbl[2+i].dm    = (i >= 20 && i < 28) ? 8'h20 : 8'h00;
            tbl[2+i].na    = anode(i);
            tbl[2+i].seg   = ((i / 4) == 5) ? 8'h40 : 8'hC0;
            tbl[2+i].busy  = 1'b0;
            tbl[2+i].done  = 1'b0;
        end

        rst_n = 1'b0; en = 1'b1; value = 32'h0; dot_mask = 8'h00; load = 1'b0;

        for (int i = 0; i < 42; i++) begin
            rst_n    = tbl[i].rst_n;
            en       = tbl[i].en;
            dot_mask = tbl[i].dm;
            nxt();
            chk($sformatf("tbl%0d_na", i),   na,   tbl[i].na);
            chk($sformatf("tbl%0d_seg", i),  seg,  tbl[i].seg);
            chk($sformatf("tbl%0d_busy", i), {7'h0, busy}, {7'h0, tbl[i].busy});
            chk($sformatf("tbl%0d_done", i), {7'h0, done}, {7'h0, tbl[i].done});
        end
        dot_mask = 8'h00;

        // Load mid-frame (edge 40), second Load while Busy (edge 41) must be dropped.
        load = 1'b1; value = 32'h0000_00A8;
        nxt();
        chk("load_busy_set", {7'h0, busy}, 8'h01);
        chk("load_no_done",  {7'h0, done}, 8'h00);
        load = 1'b1; value = 32'hFFFF_FFFF;
        nxt();
        load = 1'b0; value = 32'h0;
        chk("load2_busy", {7'h0, busy}, 8'h01);
        for (int t = 42; t <= 71; t++) begin
            nxt();
            d = (t / 4) % 8;
            if (t <= 63)      exp_seg = 8'hC0;
            else if (d == 0)  exp_seg = 8'h80;
            else              exp_seg = 8'h88;
            chk($sformatf("apply_t%0d_done", t), {7'h0, done}, {7'h0, (t == 63)});
            chk($sformatf("apply_t%0d_busy", t), {7'h0, busy}, {7'h0, (t < 63)});
            chk($sformatf("apply_t%0d_na", t),   na,  anode(t));
            chk($sformatf("apply_t%0d_seg", t),  seg, exp_seg);
        end

        // En freeze: one enabled cycle at digit 2, then 10 disabled cycles with a Load inside.
        nxt();
        chk("pre_freeze_na", na, 8'hFB);
        en = 1'b0;
        for (int k = 73; k <= 82; k++) begin
            load  = (k == 74);
            value = 32'h0000_0012;
            nxt();
            chk($sformatf("freeze_k%0d_na", k),   na,  8'hFF);
            chk($sformatf("freeze_k%0d_seg", k),  seg, 8'hFF);
            chk($sformatf("freeze_k%0d_busy", k), {7'h0, busy}, {7'h0, (k >= 74)});
            chk($sformatf("freeze_k%0d_done", k), {7'h0, done}, 8'h00);
        end
        load = 1'b0;
        en   = 1'b1;
        for (int k = 83; k <= 86; k++) begin
            nxt();
            chk($sformatf("resume_k%0d_na", k),  na,  (k < 86) ? 8'hFB : 8'hF7);
            chk($sformatf("resume_k%0d_seg", k), seg, 8'hC0);
            chk($sformatf("resume_k%0d_busy", k), {7'h0, busy}, 8'h01);
        end

        // Reset while Busy: staged 0x12 is discarded, no Done, display stays zero.
        rst_n = 1'b0;
        for (int r = 0; r < 2; r++) begin
            nxt();
            chk("rst_busy", {7'h0, busy}, 8'h00);
            chk("rst_done", {7'h0, done}, 8'h00);
            chk("rst_na",   na,  8'hFF);
            chk("rst_seg",  seg, 8'hFF);
        end
        rst_n = 1'b1;
        for (int s = 0; s < 40; s++) begin
            nxt();
            chk($sformatf("post_rst_s%0d_na", s),   na,  anode(s));
            chk($sformatf("post_rst_s%0d_seg", s),  seg, 8'hC0);
            chk($sformatf("post_rst_s%0d_busy", s), {7'h0, busy}, 8'h00);
            chk($sformatf("post_rst_s%0d_done", s), {7'h0, done}, 8'h00);
        end

        // Value 0x12: digit 0 = "2", digit 1 = "1", upper digits zero (or blank with the option).
        load = 1'b1; value = 32'h0000_0012;
        nxt();
        load = 1'b0;
        chk("v12_busy", {7'h0, busy}, 8'h01);
        for (int s = 41; s <= 95; s++) begin
            nxt();
            d = (s / 4) % 8;
            if (s <= 63)     exp_seg = 8'hC0;
            else if (d == 0) exp_seg = 8'hA4;
            else if (d == 1) exp_seg = 8'hF9;
            else begin
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
                exp_seg = 8'hFF;
`else
                exp_seg = 8'hC0;
`endif
            end
            chk($sformatf("v12_s%0d_done", s), {7'h0, done}, {7'h0, (s == 63)});
            chk($sformatf("v12_s%0d_busy", s), {7'h0, busy}, {7'h0, (s < 63)});
            chk($sformatf("v12_s%0d_na", s),   na,  anode(s));
            chk($sformatf("v12_s%0d_seg", s),  seg, exp_seg);
        end

        // Load on the boundary cycle (edge 127) must wait for the next wrap (edge 159).
        value = 32'h0000_0003;
        for (int s = 96; s <= 163; s++) begin
            load = (s == 127);
            nxt();
            chk($sformatf("bnd_s%0d_done", s), {7'h0, done}, {7'h0, (s == 159)});
            chk($sformatf("bnd_s%0d_busy", s), {7'h0, busy}, {7'h0, (s >= 127 && s < 159)});
            if (s == 128) chk("bnd_digit0_old", seg, 8'hA4);
            if (s == 160) chk("bnd_digit0_new", seg, 8'hB0);
        end
        load = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
